// File: rtl/fxp_div_pkg.sv
// fxp_div_pkg: shared types and sizing helpers for the fixed-point divider.
//   state_t    - controller states (IDLE, LOAD, CALC, DONE)
//   iter_bits  - number of quotient bits produced (WIDTH + FRAC)
//   cnt_bits   - iteration counter width for a given iteration count
package fxp_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int unsigned iter_bits(input int unsigned width,
                                              input int unsigned frac);
        return width + frac;
    endfunction

    function automatic int unsigned cnt_bits(input int unsigned iters);
        return $clog2(iters);
    endfunction

endpackage

// File: rtl/fxp_div_counter.sv
// fxp_div_counter: iteration up-counter with synchronous clear and enable.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high reset (count to zero)
//   clear  - synchronous clear to zero (wins over enable)
//   enable - advance the count by one
//   last   - high while the count equals LAST (terminal count)
module fxp_div_counter #(
    parameter int unsigned CW   = 4,
    parameter int unsigned LAST = 13
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic last
);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == CW'(LAST));

endmodule

// File: rtl/fxp_divider.sv
// fxp_divider: parametrised fixed-point restoring divider, Q = (A << FRAC) / B,
// one quotient bit per cycle, start/done handshake, divide-by-zero and
// overflow flags with saturation.
// Build option: define FXP_DIV_SIGNED_EN for two's-complement operands and
// result; undefined gives a purely unsigned divider.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high reset
//   start  - request, accepted only while ready=1
//   a_in   - dividend (WIDTH), sampled on accept
//   b_in   - divisor (WIDTH), sampled on accept
//   ready  - idle, can accept start
//   done   - one-cycle pulse when the result is valid
//   q_out  - quotient (WIDTH), held until the next accept
//   dvz    - divide-by-zero flag of the last operation
//   ovf    - overflow flag of the last operation
module fxp_divider
    import fxp_div_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned FRAC  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] q_out,
    output logic             dvz,
    output logic             ovf
);

    localparam int unsigned N  = iter_bits(WIDTH, FRAC);
    localparam int unsigned CW = cnt_bits(N);

    state_t state, state_next;

    logic [WIDTH-1:0] a_r, b_r;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] acc, acc_next;
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [N-1:0]     sreg;
    // Only N-1 quotient bits are stored; the final bit joins them in q_next.
    logic [N-2:0]     qreg;
    logic [N-1:0]     q_next;
    logic [WIDTH-1:0] res_q;
    logic             res_ovf;
    logic             cnt_clear, cnt_en, cnt_last;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: state_next = (b_r == '0) ? DONE : CALC;
            CALC: if (cnt_last) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready     = (state == IDLE);
        done      = (state == DONE);
        cnt_clear = (state == LOAD);
        cnt_en    = (state == CALC);
    end

    fxp_div_counter #(
        .CW   (CW),
        .LAST (N - 1)
    ) u_iter_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .last   (cnt_last)
    );

    // ---------------- datapath: combinational ----------------
`ifdef FXP_DIV_SIGNED_EN
    logic sign;

    localparam logic [N-1:0] LIM_NEG = N'(1) << (WIDTH - 1);
    localparam logic [N-1:0] LIM_POS = LIM_NEG - N'(1);

    // The magnitude of the most negative value, 2^(WIDTH-1), is held exactly
    // as an unsigned WIDTH-bit number, so no extra magnitude bit is stored.
    always_comb begin
        a_mag = a_r[WIDTH-1] ? (~a_r + 1'b1) : a_r;
        b_mag = b_r[WIDTH-1] ? (~b_r + 1'b1) : b_r;
    end
`else
    always_comb begin
        a_mag = a_r;
        b_mag = b_r;
    end
`endif

    always_comb begin
        trial    = {acc, sreg[N-1]};
        ge       = (trial >= {1'b0, b_r});
        acc_next = ge ? (trial[WIDTH-1:0] - b_r) : trial[WIDTH-1:0];
        q_next   = {qreg, ge};
    end

    always_comb begin
`ifdef FXP_DIV_SIGNED_EN
        res_ovf = sign ? (q_next > LIM_NEG) : (q_next > LIM_POS);
        if (res_ovf) begin
            res_q = sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res_q = sign ? (~q_next[WIDTH-1:0] + 1'b1) : q_next[WIDTH-1:0];
        end
`else
        res_ovf = ((q_next >> WIDTH) != '0);
        res_q   = res_ovf ? '1 : q_next[WIDTH-1:0];
`endif
    end

    // ---------------- datapath: registers ----------------
    // The result is registered on the last CALC edge (using q_next) so q_out
    // and the flags change on the same edge that enters DONE and raises done.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            sreg  <= '0;
            qreg  <= '0;
            q_out <= '0;
            dvz   <= 1'b0;
            ovf   <= 1'b0;
`ifdef FXP_DIV_SIGNED_EN
            sign  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a_in;
                        b_r   <= b_in;
                        q_out <= '0;
                        dvz   <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                LOAD: begin
                    acc  <= '0;
                    sreg <= N'(a_mag) << FRAC;
                    qreg <= '0;
                    b_r  <= b_mag;
`ifdef FXP_DIV_SIGNED_EN
                    sign <= a_r[WIDTH-1] ^ b_r[WIDTH-1];
`endif
                    if (b_r == '0) begin
                        dvz <= 1'b1;
                    end
                end
                CALC: begin
                    acc  <= acc_next;
                    sreg <= {sreg[N-2:0], 1'b0};
                    qreg <= q_next[N-2:0];
                    if (cnt_last) begin
                        q_out <= res_q;
                        ovf   <= res_ovf;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_divider.sv
// tb_fxp_divider: scoreboard bench for fxp_divider (WIDTH=10, FRAC=4).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and
// compares them whenever done is high. Signed vectors are used when
// FXP_DIV_SIGNED_EN is defined, unsigned vectors otherwise.
module tb_fxp_divider;

    localparam int unsigned WIDTH = 10;
    localparam int unsigned FRAC  = 4;
    localparam int unsigned N     = WIDTH + FRAC;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] q_out;
    logic             dvz;
    logic             ovf;

    fxp_divider #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .ready (ready),
        .done  (done),
        .q_out (q_out),
        .dvz   (dvz),
        .ovf   (ovf)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             dz;
        logic             ov;
        int unsigned      edge_acc;
        int unsigned      lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every done pulse against the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("q_out", 32'(q_out), 32'(e.q));
                check("dvz", 32'(dvz), 32'(e.dz));
                check("ovf", 32'(ovf), 32'(e.ov));
                check("latency", 32'(cyc + 1 - e.edge_acc), 32'(e.lat));
            end
        end
    end

    task automatic push_exp(input logic [WIDTH-1:0] q, input logic dz, input logic ov);
        exp_t e;
        e.q        = q;
        e.dz       = dz;
        e.ov       = ov;
        e.edge_acc = cyc + 1;
        e.lat      = dz ? 2 : N + 2;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=%b, expected 1", ready);
        end
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] q, input logic dz, input logic ov);
        @(negedge clock);
        wait_ready();
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        push_exp(q, dz, ov);
        @(negedge clock);
        start = 1'b0;
        a_in  = ~a;
        b_in  = ~b;
        wait_drain(40);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clock);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q_out", 32'(q_out), 32'd0);
        check("rst_dvz", 32'(dvz), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;

`ifdef FXP_DIV_SIGNED_EN
        issue(10'd12,  10'd5,   10'h026, 1'b0, 1'b0);
        issue(10'h3F4, 10'd5,   10'h3DA, 1'b0, 1'b0);
        issue(10'h3F4, 10'h3FB, 10'h026, 1'b0, 1'b0);
        issue(10'd100, 10'd0,   10'h000, 1'b1, 1'b0);
        issue(10'h200, 10'd1,   10'h200, 1'b0, 1'b1);
        issue(10'd511, 10'h3FF, 10'h200, 1'b0, 1'b1);
        issue(10'd31,  10'd1,   10'h1F0, 1'b0, 1'b0);
        issue(10'd32,  10'd1,   10'h1FF, 1'b0, 1'b1);
        issue(10'h3E0, 10'd1,   10'h200, 1'b0, 1'b0);
`else
        issue(10'd12,   10'd5,    10'h026, 1'b0, 1'b0);
        issue(10'd100,  10'd0,    10'h000, 1'b1, 1'b0);
        issue(10'd0,    10'd7,    10'h000, 1'b0, 1'b0);
        issue(10'd1023, 10'd1,    10'h3FF, 1'b0, 1'b1);
        issue(10'd1,    10'd3,    10'h005, 1'b0, 1'b0);
        issue(10'd1023, 10'd1023, 10'h010, 1'b0, 1'b0);
        issue(10'd63,   10'd4,    10'h0FC, 1'b0, 1'b0);
        issue(10'd63,   10'd1,    10'h3F0, 1'b0, 1'b0);
        issue(10'd64,   10'd1,    10'h3FF, 1'b0, 1'b1);
`endif

        // Reset while in CALC: no done may follow, outputs return to reset values.
        @(negedge clock);
        wait_ready();
        a_in  = 10'd12;
        b_in  = 10'd5;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_q_out", 32'(q_out), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_dvz", 32'(dvz), 32'd0);
        repeat (20) @(negedge clock);
        issue(10'd12, 10'd5, 10'h026, 1'b0, 1'b0);

        // start held high: accepts exactly every N+3 cycles.
        @(negedge clock);
        wait_ready();
        a_in  = 10'd12;
        b_in  = 10'd5;
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            check("held_ready", 32'(ready), ((i % (N + 3)) == 0) ? 32'd1 : 32'd0);
            if ((i % (N + 3)) == 0) begin
                push_exp(10'h026, 1'b0, 1'b0);
            end
            @(negedge clock);
        end
        start = 1'b0;
        wait_drain(60);
        repeat (5) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
